tlb_search_arbiter: RTL

TLB_SEARCH_ARBITER -- requirements
Module: tlb_search_arbiter

---
 rtl/tlb_search_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tlb_search_arbiter.sv
// TLB search-port arbiter: shares one TLB search port between the ITLB
// buffer-miss walker, the DTLB buffer-miss walker and the CP0 TLBP probe.
// Each transaction is IDLE -> LOOKUP (search strobe) -> RESP (Done pulse),
// and the registered result is held on Rsp_* for the owner.
module tlb_search_arbiter #(
  parameter int unsigned TLB_IDX_W    = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TLB_ENTRY_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   I_Req,
  input  logic [18:0]            I_VPN2,
  input  logic                   D_Req,
  input  logic [18:0]            D_VPN2,
  input  logic                   P_Req,
  input  logic [18:0]            P_VPN2,
  input  logic [7:0]             CP0_ASID,
  input  logic                   TLBBuffer_Flush,
  output logic [18:0]            s_VPN2,
  output logic [7:0]             s_ASID,
  output logic                   s_Valid,
  input  logic                   s_found,
  input  logic [TLB_IDX_W-1:0]   s_index,
  input  logic [TLB_ENTRY_W-1:0] s_Entry,
  output logic                   I_Done,
  output logic                   D_Done,
  output logic                   P_Done,
  output logic                   Rsp_found,
  output logic [TLB_IDX_W-1:0]   Rsp_index,
  output logic [TLB_ENTRY_W-1:0] Rsp_Entry,
  output logic                   Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_I = 2'd0,
    OWN_D = 2'd1,
    OWN_P = 2'd2
  } owner_t;

  state_t      state, state_nx;
  owner_t      owner, grant;
  logic        settle;
  logic [1:0]  wait_cnt;
  logic [18:0] vpn2_q;
  logic [7:0]  asid_q;
  logic [18:0] grant_vpn;
  logic        starved;
  logic        any_req;
  logic        do_grant;
  logic        flush_io;
  logic        done_en;

  assign starved  = (32'(wait_cnt) == STARVE_LIMIT);
  // Buffer flushes only invalidate ITLB/DTLB walks; a TLBP probe runs to completion.
  assign flush_io = TLBBuffer_Flush && (owner != OWN_P);
  assign done_en  = (state == RESP) && !flush_io;

  // Fixed-priority pick: P > I(starved) > D > I.
  always_comb begin
    grant     = OWN_D;
    grant_vpn = D_VPN2;
    any_req   = 1'b0;
    if (P_Req) begin
      grant     = OWN_P;
      grant_vpn = P_VPN2;
      any_req   = 1'b1;
    end else if (I_Req && starved) begin
      grant     = OWN_I;
      grant_vpn = I_VPN2;
      any_req   = 1'b1;
    end else if (D_Req) begin
      grant     = OWN_D;
      grant_vpn = D_VPN2;
      any_req   = 1'b1;
    end else if (I_Req) begin
      grant     = OWN_I;
      grant_vpn = I_VPN2;
      any_req   = 1'b1;
    end
  end

  // The IDLE cycle right after a completed transaction only samples: the
  // just-served owner still holds Req there, so no grant is issued in it.
  // A flush seen in IDLE also blocks the grant.
  assign do_grant = (state == IDLE) && any_req && !settle && !TLBBuffer_Flush;

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (do_grant) state_nx = LOOKUP;
      LOOKUP:  state_nx = flush_io ? IDLE : RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and post-RESP sampling-cycle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      settle <= 1'b0;
    end else begin
      state  <= state_nx;
      settle <= done_en;
    end
  end

  // Latch the winner with its search key at grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= OWN_I;
      vpn2_q <= '0;
      asid_q <= '0;
    end else if (do_grant) begin
      owner  <= grant;
      vpn2_q <= grant_vpn;
      asid_q <= CP0_ASID;
    end
  end

  // ITLB starvation counter, only evaluated while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (TLBBuffer_Flush) begin
        wait_cnt <= '0;
      end else if (do_grant && (grant == OWN_D) && I_Req) begin
        if (wait_cnt != 2'b11) wait_cnt <= wait_cnt + 2'd1;
      end else if (do_grant && (grant == OWN_I)) begin
        wait_cnt <= '0;
      end else if (!I_Req) begin
        wait_cnt <= '0;
      end
    end
  end

  // Capture the search result on the LOOKUP->RESP edge unless the walk is flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Rsp_found <= 1'b0;
      Rsp_index <= '0;
      Rsp_Entry <= '0;
    end else if ((state == LOOKUP) && !flush_io) begin
      Rsp_found <= s_found;
      Rsp_index <= s_index;
      Rsp_Entry <= s_Entry;
    end
  end

  assign s_Valid = (state == LOOKUP);
  assign s_VPN2  = vpn2_q;
  assign s_ASID  = asid_q;
  assign Busy    = (state != IDLE);
  assign I_Done  = done_en && (owner == OWN_I);
  assign D_Done  = done_en && (owner == OWN_D);
  assign P_Done  = done_en && (owner == OWN_P);

endmodule
